// File: rtl/ecpu_spi_master_if.sv
// eCPU-side command/status and SPI pin bundle for ecpu_spi_master; cs_hold exists only with ECPU_SPI_CS_HOLD_EN.
interface ecpu_spi_master_if;
  logic [15:0] din;
  logic        wr_div;
  logic        wr_tx;
  logic        rd_rx;
`ifdef ECPU_SPI_CS_HOLD_EN
  logic        cs_hold;
`endif
  logic        busy;
  logic        rx_valid;
  logic [15:0] rx_dout;
  logic        ovr;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;

  modport master (
    output busy, rx_valid, rx_dout, ovr, spi_sclk, spi_cs_n, spi_mosi,
`ifdef ECPU_SPI_CS_HOLD_EN
    input  cs_hold,
`endif
    input  din, wr_div, wr_tx, rd_rx, spi_miso
  );

  modport slave (
    input  busy, rx_valid, rx_dout, ovr, spi_sclk, spi_cs_n, spi_mosi,
`ifdef ECPU_SPI_CS_HOLD_EN
    output cs_hold,
`endif
    output din, wr_div, wr_tx, rd_rx, spi_miso
  );
endinterface

// File: rtl/ecpu_spi_master.sv
// Mode-0 16-bit SPI master, H=div+1 half-period, transfer done at E0+33H; wr_tx while busy is dropped and flags ovr.
// ECPU_SPI_CS_HOLD_EN adds cs_hold to keep CS low between words for multi-word frames.
module ecpu_spi_master #(
  parameter int DIV_W = 8
) (
  input logic               clk,
  input logic               rst,
  ecpu_spi_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_div_act;
  logic [DIV_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic [15:0]      r_tx;
  logic [15:0]      r_rx;
  logic [15:0]      r_rx_dout;
  logic             r_sclk;
  logic             r_cs_n;
  logic             r_mosi;
  logic             r_busy;
  logic             r_rx_valid;
  logic             r_ovr;

  logic             w_tick;
  logic             w_last;
  logic             w_load;
  logic             w_rise;
  logic             w_fall;
  logic             w_done;
  logic             w_cs_keep;
  logic [DIV_W-1:0] w_div_src;

  assign w_tick    = (r_cnt == r_div_act);
  assign w_last    = (r_bit == 4'd15);
  assign w_div_src = bus.din[DIV_W-1:0];

`ifdef ECPU_SPI_CS_HOLD_EN
  assign w_cs_keep = bus.cs_hold;
`else
  assign w_cs_keep = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:         if (bus.wr_tx) w_state_nxt = S_SETUP;
      S_SETUP, S_LOW: if (w_tick)    w_state_nxt = S_HIGH;
      S_HIGH:         if (w_tick)    w_state_nxt = w_last ? S_HOLD : S_LOW;
      S_HOLD:         if (w_tick)    w_state_nxt = S_IDLE;
      default:                       w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_rise = 1'b0;
    w_fall = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE:         w_load = bus.wr_tx;
      S_SETUP, S_LOW: w_rise = w_tick;
      S_HIGH:         w_fall = w_tick;
      S_HOLD:         w_done = w_tick;
      default:        w_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= '0;
      r_div_act  <= '0;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_dout  <= '0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      if (bus.wr_div) r_div <= w_div_src;

      // A divider written on the same cycle as wr_tx applies to this transfer.
      if (w_load) begin
        r_div_act <= bus.wr_div ? w_div_src : r_div;
        r_cnt     <= '0;
        r_bit     <= '0;
        r_tx      <= bus.din;
        r_rx      <= '0;
        r_mosi    <= bus.din[15];
        r_cs_n    <= 1'b0;
        r_busy    <= 1'b1;
      end else if (r_state != S_IDLE) begin
        r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
      end

      if (r_state == S_IDLE && !w_load && !w_cs_keep) r_cs_n <= 1'b1;

      if (w_rise) begin
        r_sclk <= 1'b1;
        r_rx   <= {r_rx[14:0], bus.spi_miso};
      end

      if (w_fall) begin
        r_sclk <= 1'b0;
        if (!w_last) begin
          r_tx   <= {r_tx[14:0], 1'b0};
          r_mosi <= r_tx[14];
          r_bit  <= r_bit + 4'd1;
        end
      end

      if (w_done) begin
        r_cs_n     <= ~w_cs_keep;
        r_busy     <= 1'b0;
        r_mosi     <= 1'b0;
        r_rx_dout  <= r_rx;
        r_rx_valid <= 1'b1;
      end else if (bus.rd_rx) begin
        r_rx_valid <= 1'b0;
      end

      if ((bus.wr_tx && r_busy) || (w_done && r_rx_valid && !bus.rd_rx)) r_ovr <= 1'b1;
      else if (bus.rd_rx)                                                   r_ovr <= 1'b0;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_dout  = r_rx_dout;
  assign bus.ovr      = r_ovr;
  assign bus.spi_sclk = r_sclk;
  assign bus.spi_cs_n = r_cs_n;
  assign bus.spi_mosi = r_mosi;

endmodule

// File: doc/ecpu_spi_master.md
# ecpu_spi_master

SPI master for the eCPU: the initiator-side counterpart of the host SPI slave, for driving an external SPI peripheral (synthesizer, attenuator, serial flash) from eCPU register writes. The eCPU loads a 16-bit word with a register-write strobe. The block shifts it out MSB-first in SPI mode 0 (CPOL=0, CPHA=0) at a programmable rate and captures 16 bits from MISO. It sits beside HOST on the cpu_clk domain; `busy` feeds a `ser` bit and `rx_dout` feeds the `par` input mux.

## Interface
- `DIV_W`, default 8: width of the clock-divider register.
- `clk`  in  1: cpu_clk. This is the block's only clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `din`  in  16: write data, taken from `tos[15:0]`.
- `wr_div`  in  1: when high, load the divider from `din[DIV_W-1:0]`.
- `wr_tx`  in  1: when high, load `din` and start a transfer.
- `rd_rx`  in  1: when high, acknowledge `rx_dout`; clears `rx_valid` and `ovr`.
- `cs_hold`  in  1: keep CS asserted after a transfer. Present only with `ECPU_SPI_CS_HOLD_EN`.
- `busy`  out  1: a transfer is in progress.
- `rx_valid`  out  1: `rx_dout` holds an unread received word.
- `rx_dout`  out  16: the last received word.
- `ovr`  out  1: sticky error flag for a lost command or a lost received word.
- `spi_sclk`  out  1: SPI clock.
- `spi_cs_n`  out  1: SPI chip select, active-low.
- `spi_mosi`  out  1: SPI data out.
- `spi_miso`  in  1: SPI data in.

## Operation
- Reset values:
  - `spi_sclk`=0, `spi_cs_n`=1, `spi_mosi`=0.
  - `busy`=0, `rx_valid`=0, `rx_dout`=0, `ovr`=0.
  - Divider register = 0; state = IDLE.
  - Reset mid-transfer aborts immediately and asynchronously to these values. No partial word is delivered.
- Half-period: H = divider + 1 clk cycles, which gives SCLK = clk / (2H).
- When a transfer starts, the divider value is copied into an active copy. A `wr_div` during a transfer changes only the next transfer.
- State machine, states IDLE → SETUP → HIGH ⇄ LOW → HOLD → IDLE:
  - IDLE:
    - `wr_tx` loads the shift register from `din` and clears the bit counter.
    - Next state is SETUP; `cs_n`=0, `busy`=1, `mosi`=din[15].
  - SETUP and LOW: after H cycles, set `sclk`=1, shift in `spi_miso` (sampled at this edge), and go to HIGH.
  - HIGH: after H cycles, set `sclk`=0.
    - If the bit counter is 15, go to HOLD.
    - Otherwise shift MOSI to the next bit, increment the counter, and go to LOW.
  - HOLD: after H cycles, do all of the following on the same edge:
    - set `cs_n`=1 and `busy`=0;
    - set `rx_dout` = the shifted-in word and `rx_valid`=1;
    - go to IDLE.
- `mosi` is 0 in IDLE.
- `ovr` is set, and stays set until the next `rd_rx`, in two cases:
  - `wr_tx` arrives while `busy`=1. The write is ignored and the transfer in flight is unaffected.
  - A transfer completes while `rx_valid`=1 and `rd_rx` is not asserted on that cycle. The new word overwrites `rx_dout`.
- Simultaneous events:
  - Completion and `rd_rx` on the same cycle: `rx_valid` stays 1 with the new word and `ovr` is not set.
  - `rd_rx` while `rx_valid`=0: no effect beyond clearing `ovr`.
  - `wr_div` and `wr_tx` on the same cycle: the new divider applies to this transfer.

## Timing
- Let E0 be the clk edge that registers `wr_tx`.
- Outputs change on E0: `busy`=1, `cs_n`=0, `mosi`=b15.
- For bit k (0..15, MSB first):
  - SCLK rises at E0+(2k+1)H; MISO is sampled on that edge.
  - SCLK falls at E0+(2k+2)H, and MOSI advances on the same edge.
- The transfer completes at E0+33H: `cs_n`=1, `busy`=0, `rx_valid`=1.
- H=1 gives 33 cycles; H=4 gives 132 cycles.
- The earliest next `wr_tx` is on the cycle after `busy` falls. CS stays high for at least one clk cycle.
- All outputs are registered, so they are glitch-free.

## Configuration
- `ECPU_SPI_CS_HOLD_EN` defined:
  - The `cs_hold` port exists.
  - If `cs_hold`=1 at the HOLD→IDLE edge, `spi_cs_n` stays 0; `busy` and `rx_valid` behave normally.
  - A following `wr_tx` runs SETUP with CS already low, giving multi-word frames.
  - If `cs_hold` is 0 while in IDLE with CS low, `spi_cs_n`=1 on the next edge.
- `ECPU_SPI_CS_HOLD_EN` undefined: the port is absent and CS always deasserts at completion.

## Test plan
- Basic transfer, loopback: MISO tied to MOSI, divider=0, `wr_tx` din=0xA53C. Required response:
  - 16 SCLK rising edges;
  - `busy` high for exactly 33 cycles;
  - `rx_dout`=0xA53C, `rx_valid`=1, `ovr`=0.
- Divider: divider=3, MISO held at 1. Required response:
  - SCLK high and low phases of 4 cycles each;
  - completion at E0+132;
  - `rx_dout`=0xFFFF.
- Overrun:
  - A `wr_tx` 0x1234 during a transfer of 0x00FF sets `ovr`=1, and MOSI still carries 0x00FF.
  - A second completion without `rd_rx` sets `ovr`=1; `rd_rx` then clears both `rx_valid` and `ovr`.
- Simultaneous read and completion: `rd_rx` on the completion cycle → `rx_valid`=1 with the new word, `ovr`=0.
- Reset at bit 7 mid-transfer:
  - `cs_n`=1, `sclk`=0, `busy`=0, `rx_valid`=0 in the same cycle;
  - a next transfer of 0x8001 completes correctly.
- With `ECPU_SPI_CS_HOLD_EN`: two words 0x1111 and 0x2222 sent with `cs_hold`=1. Required response:
  - `cs_n` stays 0 across both words, with 32 SCLK edges;
  - `cs_n` rises one cycle after `cs_hold` drops.
